// File: rtl/pipe_seg_hs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_seg_hs_pkg                                                  |
// | Brief   : Shared field offsets and skid state encoding for pipe segments.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_seg_hs_pkg;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_t;

   // EX/MEM control-field bit layout (CW = 16)
   localparam int c_exmem_regwen  = 0;
   localparam int c_exmem_data_en = 1;
   localparam int c_exmem_wen_lo  = 2;
   localparam int c_exmem_wen_hi  = 5;
   localparam int c_exmem_wreg_lo = 6;
   localparam int c_exmem_wreg_hi = 11;
   localparam int c_exmem_rhilo_lo = 12;
   localparam int c_exmem_rhilo_hi = 13;
   localparam int c_exmem_whilo_lo = 14;
   localparam int c_exmem_whilo_hi = 15;

   // EX/MEM data-field packing (DW = 128)
   localparam int c_exmem_pc_lo     = 0;
   localparam int c_exmem_result_lo = 32;
   localparam int c_exmem_hi_lo     = 64;
   localparam int c_exmem_lo_lo     = 96;
   localparam int c_word_w          = 32;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_skid_buf                                                    |
// | Brief   : Skid-mode controller: EMPTY/ONE/FULL FSM plus the skid register. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_skid_buf
   import pipe_seg_hs_pkg::*;
#(
   parameter int CW = 16,
   parameter int DW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   input  logic          i_in_valid,
   input  logic [CW-1:0] i_in_ctrl,
   input  logic [DW-1:0] i_in_data,
   input  logic          i_out_ready,
   output logic          o_in_ready,
   output logic          o_m_we,
   output logic          o_m_valid,
   output logic [CW-1:0] o_m_ctrl,
   output logic          o_m_data_we,
   output logic [DW-1:0] o_m_data
);

   skid_state_t   r_state;
   skid_state_t   w_state_nxt;
   logic          r_full;
   logic [CW-1:0] r_s_ctrl;
   logic [DW-1:0] r_s_data;
   logic          w_up;
   logic          w_dn;
   logic          w_s_we;
   logic          w_s_clear;

   // in_ready comes straight from a flop so upstream sees no combinational path
   assign o_in_ready = ~r_full;
   assign w_up       = i_in_valid & ~r_full;
   assign w_dn       = i_out_ready & (r_state != SKID_EMPTY);

   always_comb begin
      w_state_nxt = r_state;
      o_m_we      = 1'b0;
      o_m_valid   = 1'b0;
      o_m_ctrl    = '0;
      o_m_data_we = 1'b0;
      o_m_data    = i_in_data;
      w_s_we      = 1'b0;
      w_s_clear   = 1'b0;
      case (r_state)
         SKID_EMPTY: begin
            if (w_up) begin
               w_state_nxt = SKID_ONE;
               o_m_we      = 1'b1;
               o_m_valid   = 1'b1;
               o_m_ctrl    = i_in_ctrl;
               o_m_data_we = 1'b1;
            end
         end
         SKID_ONE: begin
            if (w_up && w_dn) begin
               o_m_we      = 1'b1;
               o_m_valid   = 1'b1;
               o_m_ctrl    = i_in_ctrl;
               o_m_data_we = 1'b1;
            end else if (w_up) begin
               w_state_nxt = SKID_FULL;
               w_s_we      = 1'b1;
            end else if (w_dn) begin
               w_state_nxt = SKID_EMPTY;
               o_m_we      = 1'b1;
            end
         end
         SKID_FULL: begin
            if (w_dn) begin
               w_state_nxt = SKID_ONE;
               o_m_we      = 1'b1;
               o_m_valid   = 1'b1;
               o_m_ctrl    = r_s_ctrl;
               o_m_data_we = 1'b1;
               o_m_data    = r_s_data;
               w_s_clear   = 1'b1;
            end
         end
         default: w_state_nxt = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= SKID_EMPTY;
         r_full   <= 1'b0;
         r_s_ctrl <= '0;
         r_s_data <= '0;
      end else if (i_flush) begin
         r_state  <= SKID_EMPTY;
         r_full   <= 1'b0;
         r_s_ctrl <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_full  <= (w_state_nxt == SKID_FULL);
         if (w_s_we) begin
            r_s_ctrl <= i_in_ctrl;
            r_s_data <= i_in_data;
         end else if (w_s_clear) begin
            r_s_ctrl <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_seg_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_seg_hs                                                      |
// | Brief   : Handshaked pipeline segment register with flush and skid option. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_seg_hs
   import pipe_seg_hs_pkg::*;
#(
   parameter int CW   = 16,
   parameter int DW   = 128,
   parameter int SKID = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_ctrl,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_ctrl,
   output logic [DW-1:0] out_data
);

   logic          r_valid;
   logic [CW-1:0] r_ctrl;
   logic [DW-1:0] r_data;
   logic          w_in_ready;
   logic          w_m_we;
   logic          w_m_valid_nxt;
   logic [CW-1:0] w_m_ctrl_nxt;
   logic          w_m_data_we;
   logic [DW-1:0] w_m_data_nxt;

   generate
      if (SKID == 0) begin : g_single
         assign w_in_ready    = out_ready | ~r_valid;
         assign w_m_we        = w_in_ready;
         assign w_m_valid_nxt = in_valid;
         assign w_m_ctrl_nxt  = in_valid ? in_ctrl : '0;
         assign w_m_data_we   = in_valid;
         assign w_m_data_nxt  = in_data;
      end else begin : g_skid
         pipe_skid_buf #(
            .CW (CW),
            .DW (DW)
         ) u_skid (
            .clk         (clk),
            .rst         (reset),
            .i_flush     (flush),
            .i_in_valid  (in_valid),
            .i_in_ctrl   (in_ctrl),
            .i_in_data   (in_data),
            .i_out_ready (out_ready),
            .o_in_ready  (w_in_ready),
            .o_m_we      (w_m_we),
            .o_m_valid   (w_m_valid_nxt),
            .o_m_ctrl    (w_m_ctrl_nxt),
            .o_m_data_we (w_m_data_we),
            .o_m_data    (w_m_data_nxt)
         );
      end
   endgenerate

   // Data is only ever reloaded, never cleared, so bubbles keep the last payload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (w_m_we) begin
         r_valid <= w_m_valid_nxt;
         r_ctrl  <= w_m_ctrl_nxt;
         if (w_m_data_we) begin
            r_data <= w_m_data_nxt;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_valid;
   assign out_ctrl  = r_ctrl;
   assign out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_seg_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipe_seg_hs                                                   |
// | Brief   : Directed bench for pipe_seg_hs in single (SKID=0) and skid mode. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_seg_hs;

   localparam int CW = 16;
   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          flush;

   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [CW-1:0] a_in_ctrl, a_out_ctrl;
   logic [DW-1:0] a_in_data, a_out_data;

   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [CW-1:0] b_in_ctrl, b_out_ctrl;
   logic [DW-1:0] b_in_data, b_out_data;

   int n_vec = 0;
   int n_err = 0;

   pipe_seg_hs #(.CW(CW), .DW(DW), .SKID(0)) u_dut_single (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_ctrl   (a_in_ctrl),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_ctrl  (a_out_ctrl),
      .out_data  (a_out_data)
   );

   pipe_seg_hs #(.CW(CW), .DW(DW), .SKID(1)) u_dut_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_ctrl   (b_in_ctrl),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_ctrl  (b_out_ctrl),
      .out_data  (b_out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic rdy);
      a_in_valid  = v;
      a_in_ctrl   = d[CW-1:0];
      a_in_data   = d;
      a_out_ready = rdy;
   endtask

   task automatic drive_b(input logic v, input logic [DW-1:0] d, input logic rdy);
      b_in_valid  = v;
      b_in_ctrl   = d[CW-1:0];
      b_in_data   = d;
      b_out_ready = rdy;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      drive_a(1'b0, '0, 1'b0);
      drive_b(1'b0, '0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_ctrl",  a_out_ctrl,  0);
      chk("rst_a_data",  a_out_data,  0);
      chk("rst_a_ready", a_in_ready,  1);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_ready", b_in_ready,  1);

      // asynchronous reset with a live all-ones control entry
      a_in_valid = 1'b1; a_in_ctrl = 16'hFFFF; a_in_data = 32'h55; a_out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", a_out_valid, 1);
      chk("pre_rst_ctrl",  a_out_ctrl,  16'hFFFF);
      a_in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", a_out_valid, 0);
      chk("async_rst_ctrl",  a_out_ctrl,  0);
      chk("async_rst_data",  a_out_data,  0);
      #2 reset = 1'b0;
      #1;
      chk("post_rst_ready", a_in_ready, 1);
      tick();

      // streaming 1..4 with no back-pressure
      for (int i = 1; i <= 4; i++) begin
         drive_a(1'b1, DW'(i), 1'b1);
         tick();
         chk("stream_valid", a_out_valid, 1);
         chk("stream_data",  a_out_data,  i);
         chk("stream_ctrl",  a_out_ctrl,  i);
      end
      // bubble after a valid entry
      drive_a(1'b0, 32'hEE, 1'b1);
      tick();
      chk("bubble_valid", a_out_valid, 0);
      chk("bubble_ctrl",  a_out_ctrl,  0);
      chk("bubble_data",  a_out_data,  4);

      // stall holding A5
      drive_a(1'b1, 32'hA5, 1'b1);
      tick();
      chk("stall_load", a_out_data, 32'hA5);
      drive_a(1'b1, 32'hB6, 1'b0);
      #1;
      chk("stall_ready0", a_in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", a_out_valid, 1);
         chk("stall_data",  a_out_data,  32'hA5);
         chk("stall_ctrl",  a_out_ctrl,  16'hA5);
         chk("stall_ready", a_in_ready,  0);
      end
      a_out_ready = 1'b1;
      #1;
      chk("release_ready", a_in_ready, 1);
      tick();
      chk("release_data",  a_out_data, 32'hB6);
      chk("release_valid", a_out_valid, 1);

      // flush discards a simultaneously accepted input
      drive_a(1'b1, 32'h33, 1'b1);
      tick();
      chk("a_preflush", a_out_data, 32'h33);
      drive_a(1'b1, 32'h9, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("a_flush_valid", a_out_valid, 0);
      chk("a_flush_ctrl",  a_out_ctrl,  0);
      chk("a_flush_data",  a_out_data,  32'h33);
      chk("a_flush_ready", a_in_ready,  1);
      drive_a(1'b0, '0, 1'b1);
      tick();
      chk("a_postflush_valid", a_out_valid, 0);

      // skid: pass-through replace in ONE
      drive_b(1'b1, 32'h11, 1'b1);
      tick();
      chk("b_one_data", b_out_data, 32'h11);
      drive_b(1'b1, 32'h22, 1'b1);
      tick();
      chk("b_replace_data",  b_out_data, 32'h22);
      chk("b_replace_ready", b_in_ready, 1);
      drive_b(1'b0, '0, 1'b1);
      tick();
      chk("b_drain_valid", b_out_valid, 0);
      chk("b_drain_ctrl",  b_out_ctrl,  0);
      chk("b_drain_data",  b_out_data,  32'h22);

      // skid fill with 7 then 8 under back-pressure
      drive_b(1'b1, 32'h7, 1'b0);
      tick();
      chk("fill7_valid", b_out_valid, 1);
      chk("fill7_data",  b_out_data,  32'h7);
      chk("fill7_ready", b_in_ready,  1);
      drive_b(1'b1, 32'h8, 1'b0);
      tick();
      chk("full_ready", b_in_ready, 0);
      chk("full_data",  b_out_data, 32'h7);
      drive_b(1'b1, 32'h99, 1'b0);
      tick();
      chk("full_hold_data",  b_out_data, 32'h7);
      chk("full_hold_ctrl",  b_out_ctrl, 16'h7);
      chk("full_hold_ready", b_in_ready, 0);
      drive_b(1'b0, '0, 1'b1);
      tick();
      chk("out8_data",  b_out_data, 32'h8);
      chk("out8_ctrl",  b_out_ctrl, 16'h8);
      chk("out8_ready", b_in_ready, 1);
      tick();
      chk("b_empty_valid", b_out_valid, 0);
      chk("b_empty_ctrl",  b_out_ctrl,  0);

      // flush from FULL with a simultaneous input
      drive_b(1'b1, 32'h1, 1'b0);
      tick();
      drive_b(1'b1, 32'h2, 1'b0);
      tick();
      chk("b_full2_ready", b_in_ready, 0);
      drive_b(1'b1, 32'h9, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("b_flush_valid", b_out_valid, 0);
      chk("b_flush_ctrl",  b_out_ctrl,  0);
      chk("b_flush_ready", b_in_ready,  1);
      chk("b_flush_data",  b_out_data,  32'h1);
      drive_b(1'b0, '0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("b_no9_valid", b_out_valid, 0);
      end

      // asynchronous reset while FULL
      drive_b(1'b1, 32'h3, 1'b0);
      tick();
      drive_b(1'b1, 32'h4, 1'b0);
      tick();
      chk("b_full3_ready", b_in_ready, 0);
      drive_b(1'b0, '0, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("b_rst_valid", b_out_valid, 0);
      chk("b_rst_data",  b_out_data,  0);
      #2 reset = 1'b0;
      #1;
      chk("b_rst_ready", b_in_ready, 1);
      tick();
      chk("b_rst_nothing_left", b_out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
